// File: rtl/r32_bus_arbiter.sv
// Round-robin arbiter sharing the R32 memory bus between fetch (F) and load/store (D); bus request 1 cycle after grant, read response 1 cycle after s_valid.
// Backpressure: m_ready=0 holds the registered request and blocks new grants; reads stall once MAX_OUT reads are outstanding.
module r32_bus_arbiter #(
    parameter int ADDR_W  = 33,
    parameter int DATA_W  = 33,
    parameter int MAX_OUT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_address,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_write,
    input  logic              d_valid,
    output logic              d_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data,
    output logic              m_write,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid
);

    localparam int            CW      = $clog2(MAX_OUT);
    localparam logic [CW:0]   MAX_CNT = (CW+1)'(MAX_OUT);
    localparam logic          OWN_F   = 1'b0;
    localparam logic          OWN_D   = 1'b1;

    logic [ADDR_W-1:0] m_address_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_write_q;
    logic              m_valid_q;
    logic              last_grant_q;
    logic [CW:0]       count_q, count_d;
    logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
    logic              tag_q [MAX_OUT];
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
    logic              f_rvalid_q, d_rvalid_q;

    logic slot_free, f_elig, d_elig, grant_f, grant_d, push, pop, head_own;

    always_comb begin
        slot_free = !m_valid_q || m_ready;
        // Credit check uses the registered count only; a response popped this cycle frees a slot next cycle.
        f_elig    = f_valid && (count_q < MAX_CNT);
        d_elig    = d_valid && (d_write || (count_q < MAX_CNT));
        grant_f   = slot_free && f_elig && (!d_elig || last_grant_q == OWN_D);
        grant_d   = slot_free && d_elig && (!f_elig || last_grant_q == OWN_F);
        push      = grant_f || (grant_d && !d_write);
        pop       = s_valid && (count_q != '0);
        head_own  = tag_q[rd_ptr_q];
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_address_q  <= '0;
            m_data_q     <= '0;
            m_write_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            last_grant_q <= OWN_D;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < MAX_OUT; i++) tag_q[i] <= OWN_F;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            if (grant_f || grant_d) begin
                m_valid_q    <= 1'b1;
                m_address_q  <= grant_f ? f_address : d_address;
                m_data_q     <= grant_f ? '0 : d_data;
                m_write_q    <= grant_d && d_write;
                last_grant_q <= grant_f ? OWN_F : OWN_D;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (push) begin
                tag_q[wr_ptr_q] <= grant_f ? OWN_F : OWN_D;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            f_rvalid_q <= pop && (head_own == OWN_F);
            d_rvalid_q <= pop && (head_own == OWN_D);
            if (pop && head_own == OWN_F) f_rdata_q <= s_data;
            if (pop && head_own == OWN_D) d_rdata_q <= s_data;
        end
    end

    assign f_ready   = grant_f;
    assign d_ready   = grant_d;
    assign m_address = m_address_q;
    assign m_data    = m_data_q;
    assign m_write   = m_write_q;
    assign m_valid   = m_valid_q;
    assign s_ready   = (count_q != '0);
    assign f_rdata   = f_rdata_q;
    assign f_rvalid  = f_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_rvalid  = d_rvalid_q;

endmodule

// File: tb/tb_r32_bus_arbiter.sv
// Directed bench for r32_bus_arbiter: inputs driven 1ns after the rising edge, outputs sampled there too.
module tb_r32_bus_arbiter;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 33;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] f_address = '0;
    logic              f_valid = 1'b0;
    logic              f_ready;
    logic [ADDR_W-1:0] d_address = '0;
    logic [DATA_W-1:0] d_data = '0;
    logic              d_write = 1'b0;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_data;
    logic              m_write;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] f_rdata;
    logic              f_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    int checks = 0;
    int errors = 0;

    r32_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(4)) dut (
        .clock(clock), .reset(reset),
        .f_address(f_address), .f_valid(f_valid), .f_ready(f_ready),
        .d_address(d_address), .d_data(d_data), .d_write(d_write),
        .d_valid(d_valid), .d_ready(d_ready),
        .m_address(m_address), .m_data(m_data), .m_write(m_write),
        .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .f_rdata(f_rdata), .f_rvalid(f_rvalid),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        f_valid = 1'b0; d_valid = 1'b0; d_write = 1'b0; s_valid = 1'b0;
        m_ready = 1'b0; f_address = '0; d_address = '0; d_data = '0; s_data = '0;
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        step();
    endtask

    initial begin
        // Reset then single F read
        do_reset();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_address", 64'(m_address), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_write", 64'(m_write), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("rst_f_rdata", 64'(f_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("idle_f_ready", 64'(f_ready), 64'd0);
        f_valid = 1'b1; f_address = 33'h100; m_ready = 1'b1;
        #1;
        chk("t1_f_ready", 64'(f_ready), 64'd1);
        chk("t1_d_ready", 64'(d_ready), 64'd0);
        step();
        f_valid = 1'b0;
        chk("t1_m_valid", 64'(m_valid), 64'd1);
        chk("t1_m_address", 64'(m_address), 64'h100);
        chk("t1_m_write", 64'(m_write), 64'd0);
        chk("t1_m_data", 64'(m_data), 64'd0);
        chk("t1_s_ready", 64'(s_ready), 64'd1);
        step();
        chk("t1_m_valid_drop", 64'(m_valid), 64'd0);
        s_valid = 1'b1; s_data = 33'h55;
        step();
        s_valid = 1'b0;
        chk("t1_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("t1_f_rdata", 64'(f_rdata), 64'h55);
        chk("t1_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("t1_s_ready_empty", 64'(s_ready), 64'd0);
        step();
        chk("t1_f_rvalid_pulse", 64'(f_rvalid), 64'd0);

        // Round-robin alternation, F first after reset
        do_reset();
        m_ready = 1'b1;
        f_valid = 1'b1; f_address = 33'h1F0;
        d_valid = 1'b1; d_write = 1'b1; d_address = 33'h2E0; d_data = 33'h1BEEF;
        #1;
        chk("rr0_f_ready", 64'(f_ready), 64'd1);
        chk("rr0_d_ready", 64'(d_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_m_valid", 64'(m_valid), 64'd1);
            if (i % 2 == 0) begin
                chk("rr_f_addr", 64'(m_address), 64'h1F0);
                chk("rr_f_write", 64'(m_write), 64'd0);
                chk("rr_f_data", 64'(m_data), 64'd0);
                chk("rr_d_turn", 64'(d_ready), 64'd1);
            end else begin
                chk("rr_d_addr", 64'(m_address), 64'h2E0);
                chk("rr_d_write", 64'(m_write), 64'd1);
                chk("rr_d_data", 64'(m_data), 64'h1BEEF);
                chk("rr_f_turn", 64'(f_ready), 64'd1);
            end
        end

        // Hold stable under m_ready=0
        do_reset();
        d_valid = 1'b1; d_write = 1'b1; d_address = 33'h20; d_data = 33'h1234;
        #1;
        chk("hold_d_ready0", 64'(d_ready), 64'd1);
        step();
        d_address = 33'h40; d_data = 33'h5678;
        for (int i = 0; i < 3; i++) begin
            chk("hold_m_valid", 64'(m_valid), 64'd1);
            chk("hold_m_address", 64'(m_address), 64'h20);
            chk("hold_m_data", 64'(m_data), 64'h1234);
            chk("hold_m_write", 64'(m_write), 64'd1);
            chk("hold_d_ready", 64'(d_ready), 64'd0);
            step();
        end
        m_ready = 1'b1;
        #1;
        chk("hold_release_d_ready", 64'(d_ready), 64'd1);
        step();
        d_valid = 1'b0;
        chk("hold_b2b_valid", 64'(m_valid), 64'd1);
        chk("hold_b2b_addr", 64'(m_address), 64'h40);
        chk("hold_b2b_data", 64'(m_data), 64'h5678);
        step();
        chk("hold_end_valid", 64'(m_valid), 64'd0);

        // Outstanding-read limit
        do_reset();
        m_ready = 1'b1; f_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_address = 33'(32'h200 + 32'(i * 4));
            #1;
            chk("lim_f_ready", 64'(f_ready), 64'd1);
            step();
        end
        f_address = 33'h210;
        #1;
        chk("lim_f_stall", 64'(f_ready), 64'd0);
        d_valid = 1'b1; d_write = 1'b1; d_address = 33'h300; d_data = 33'h9;
        #1;
        chk("lim_store_ok", 64'(d_ready), 64'd1);
        step();
        d_valid = 1'b0;
        chk("lim_store_addr", 64'(m_address), 64'h300);
        chk("lim_store_write", 64'(m_write), 64'd1);
        s_valid = 1'b1; s_data = 33'h77;
        #1;
        chk("lim_no_same_cycle_credit", 64'(f_ready), 64'd0);
        step();
        s_valid = 1'b0;
        chk("lim_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("lim_f_rdata", 64'(f_rdata), 64'h77);
        chk("lim_f_ready_after_pop", 64'(f_ready), 64'd1);
        step();
        f_valid = 1'b0;
        chk("lim_f_addr", 64'(m_address), 64'h210);
        chk("lim_f_write", 64'(m_write), 64'd0);

        // In-order response routing F,D,F
        do_reset();
        m_ready = 1'b1;
        f_valid = 1'b1; f_address = 33'h10;
        step();
        f_valid = 1'b0; d_valid = 1'b1; d_write = 1'b0; d_address = 33'h14;
        step();
        chk("rt_d_load_addr", 64'(m_address), 64'h14);
        d_valid = 1'b0; f_valid = 1'b1; f_address = 33'h18;
        step();
        f_valid = 1'b0;
        s_valid = 1'b1; s_data = 33'hA;
        step();
        chk("rt_a_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("rt_a_f_rdata", 64'(f_rdata), 64'hA);
        chk("rt_a_d_rvalid", 64'(d_rvalid), 64'd0);
        s_data = 33'hB;
        step();
        chk("rt_b_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("rt_b_d_rdata", 64'(d_rdata), 64'hB);
        chk("rt_b_f_rvalid", 64'(f_rvalid), 64'd0);
        s_data = 33'hC;
        step();
        s_valid = 1'b0;
        chk("rt_c_f_rvalid", 64'(f_rvalid), 64'd1);
        chk("rt_c_f_rdata", 64'(f_rdata), 64'hC);
        chk("rt_c_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("rt_c_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("rt_end_f_rvalid", 64'(f_rvalid), 64'd0);

        // Reset mid-transaction drops request and tags
        do_reset();
        f_valid = 1'b1; f_address = 33'h500;
        step();
        m_ready = 1'b1; f_address = 33'h504;
        step();
        f_valid = 1'b0; m_ready = 1'b0;
        chk("mr_m_valid", 64'(m_valid), 64'd1);
        chk("mr_m_address", 64'(m_address), 64'h504);
        chk("mr_s_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;
        #1;
        chk("mr_async_m_valid", 64'(m_valid), 64'd0);
        chk("mr_async_s_ready", 64'(s_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        s_valid = 1'b1; s_data = 33'h99;
        #1;
        chk("mr_late_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("mr_late_f_rvalid", 64'(f_rvalid), 64'd0);
        chk("mr_late_d_rvalid", 64'(d_rvalid), 64'd0);
        step();
        s_valid = 1'b0;
        chk("mr_late2_f_rvalid", 64'(f_rvalid), 64'd0);
        chk("mr_late2_d_rvalid", 64'(d_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/r32_bus_arbiter.md
Name: r32_bus_arbiter

Overview:
- Shares the R32 master memory bus (m_address/m_data/m_valid/m_ready) between two requesters: instruction fetch (F, reads only) and data load/store (D, reads and writes).
- Round-robin grant, registered bus output stage, in-order read-response routing through an owner-tag FIFO.
- Sits between the core's fetch/LSU units and the memory port.

Parameters:
- ADDR_W, 33, address width (matches the R32 bus).
- DATA_W, 33, data width (matches the R32 bus).
- MAX_OUT, 4, max outstanding reads (tag FIFO depth), power of two >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_address  in  ADDR_W  fetch read address.
- f_valid  in  1  fetch request pending.
- f_ready  out  1  fetch request accepted this cycle (combinational).
- d_address  in  ADDR_W  data request address.
- d_data  in  DATA_W  store data.
- d_write  in  1  1=store, 0=load.
- d_valid  in  1  data request pending.
- d_ready  out  1  data request accepted this cycle (combinational).
- m_address  out  ADDR_W  bus address (registered).
- m_data  out  DATA_W  bus write data (registered).
- m_write  out  1  bus write flag (registered).
- m_valid  out  1  bus request valid (registered).
- m_ready  in  1  bus accepts the current request.
- s_data  in  DATA_W  read response data.
- s_valid  in  1  read response valid.
- s_ready  out  1  arbiter can take a response (tag FIFO non-empty).
- f_rdata  out  DATA_W  fetch response data (registered).
- f_rvalid  out  1  fetch response pulse.
- d_rdata  out  DATA_W  load response data (registered).
- d_rvalid  out  1  load response pulse.

Behaviour:
- Reset (reset=0, async): m_valid=0, m_address=0, m_data=0, m_write=0, f_rvalid=d_rvalid=0, f_rdata=d_rdata=0, tag FIFO empty (s_ready=0), count=0, last_grant=D (F wins the first tie).
- slot_free = !m_valid || m_ready.
- A request is eligible when valid is high and, if it is a read, count < MAX_OUT. F is always a read; D is a read when d_write=0. No credit is given for a same-cycle response pop.
- Selection with slot_free=1:
  - Only one requester eligible: that requester is selected.
  - Both eligible: the one not equal to last_grant is selected.
- The selected requester's ready=1 for that cycle. Ready stays 0 whenever slot_free=0.
- On a grant (next edge):
  - m_valid<=1; m_address/m_data/m_write are loaded from the winner. F drives m_data=0 and m_write=0.
  - last_grant<=winner.
  - For a read, the owner bit is pushed into the tag FIFO and count increments.
- Hold: while m_valid=1 and m_ready=0, all m_* outputs stay stable.
- m_valid&&m_ready with no new grant: m_valid<=0. With a new grant in the same cycle: back-to-back, no bubble.
- Response routing: when s_valid&&s_ready, the FIFO head is popped and count decrements. On the next edge:
  - owner=F: f_rdata<=s_data, f_rvalid<=1.
  - owner=D: d_rdata<=s_data, d_rvalid<=1.
  - Latency is 1 cycle; rvalid deasserts the following cycle unless another response arrives.
- Simultaneous push and pop: count unchanged; FIFO pointers both advance.
- count never exceeds MAX_OUT. At count==MAX_OUT reads stall, and D stores may still be granted.
- Responders assume always-ready consumers; no backpressure on r-channels.
- s_valid while the FIFO is empty: ignored (s_ready=0); no rvalid is produced.
- Reset mid-transaction: the pending bus request and all outstanding tags are dropped. Late responses are ignored because s_ready=0.

Test Plan:
- Reset then idle: all outputs 0, s_ready=0. F requests 0x100 with m_ready=1 -> f_ready=1 that cycle; next cycle m_valid=1, m_address=0x100, m_write=0; the following cycle m_valid=0.
- F and D both valid continuously, m_ready=1 -> grants alternate F,D,F,D starting with F; m_valid stays 1 with no bubble.
- D store addr 0x20, data 0x1234, m_ready=0 for 3 cycles -> m_* held stable for 3 cycles; d_ready=0 for the new D request; release on m_ready=1.
- Issue 4 F reads with no responses (MAX_OUT=4) -> 5th F read stalls (f_ready=0); a D store is still granted; one s_valid -> the F read is granted after the count drops.
- Reads in order F,D,F; responses 0xA,0xB,0xC -> f_rvalid with 0xA, then d_rvalid with 0xB, then f_rvalid with 0xC, each one cycle after its s_valid.
- Assert reset low with m_valid=1 and 2 reads outstanding -> m_valid=0 immediately; then s_valid=1 after release -> no rvalid, s_ready=0.
